// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for the byte-addressed data memory.
// Optional macro LSU_ALIGN_CHECK_EN adds half/word alignment errors.
module load_store_unit #(
   parameter int BitWidth = 32,
   parameter int Capacity = 128,
   localparam int AddrWidth = $clog2(Capacity)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_signed,
   input  logic [31:0]          req_addr,
   input  logic [BitWidth-1:0]  req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [BitWidth-1:0]  resp_rdata,
   output logic                 resp_error,
   output logic                 mem_enable,
   output logic                 mem_write,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [BitWidth-1:0]  mem_wdata,
   output logic [BitWidth-1:0]  mem_wmask,
   input  logic [BitWidth-1:0]  mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [AddrWidth:0] CapLimit = Capacity[AddrWidth:0];

   state_t state;
   state_t next_state;

   logic                 wr_q;
   logic [1:0]           size_q;
   logic                 sgn_q;
   logic [AddrWidth-1:0] addr_q;
   logic [BitWidth-1:0]  wdata_q;
   logic                 err_q;

   logic [AddrWidth:0]   bytes;
   logic [AddrWidth:0]   end_sum;
   logic                 err;
   logic [BitWidth-1:0]  mask;
   logic [BitWidth-1:0]  ext;

   // Request check: illegal size, address above capacity, or access running past the end.
   always_comb begin
      bytes = '0;
      unique case (req_size)
         2'd0:    bytes = (AddrWidth+1)'(1);
         2'd1:    bytes = (AddrWidth+1)'(2);
         2'd2:    bytes = (AddrWidth+1)'(4);
         default: bytes = '0;
      endcase
      end_sum = {1'b0, req_addr[AddrWidth-1:0]} + bytes;
      err = (req_size == 2'd3)
         | (|req_addr[31:AddrWidth])
         | (end_sum > CapLimit);
`ifdef LSU_ALIGN_CHECK_EN
      err = err
         | ((req_size == 2'd1) & req_addr[0])
         | ((req_size == 2'd2) & (|req_addr[1:0]));
`else
      err = err | 1'b0;
`endif
   end

   // Write mask and load extension from the latched size.
   always_comb begin
      mask = '0;
      ext  = mem_rdata;
      unique case (size_q)
         2'd0: begin
            mask = 32'h0000_00FF;
            ext  = {{24{sgn_q & mem_rdata[7]}}, mem_rdata[7:0]};
         end
         2'd1: begin
            mask = 32'h0000_FFFF;
            ext  = {{16{sgn_q & mem_rdata[15]}}, mem_rdata[15:0]};
         end
         2'd2: begin
            mask = 32'hFFFF_FFFF;
            ext  = mem_rdata;
         end
         default: begin
            mask = '0;
            ext  = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state and all handshake/memory outputs.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_enable = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wmask  = '0;
      case (state)
         IDLE: begin
            req_ready = ~reset;
            if (req_valid) next_state = ACCESS;
         end
         ACCESS: begin
            next_state = RESP;
            if (!err_q) begin
               mem_enable = 1'b1;
               mem_write  = wr_q;
               mem_addr   = addr_q;
               mem_wdata  = wdata_q;
               mem_wmask  = mask;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture the request at acceptance; req_* may change afterwards.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         wr_q    <= req_write;
         size_q  <= req_size;
         sgn_q   <= req_signed;
         addr_q  <= req_addr[AddrWidth-1:0];
         wdata_q <= req_wdata;
         err_q   <= err;
      end
   end

   // Response registers, loaded at the end of the access cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_error <= 1'b0;
      end else if (state == ACCESS) begin
         resp_error <= err_q;
         resp_rdata <= (err_q | wr_q) ? '0 : ext;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests against a byte-array model.
// Optional macro LSU_ALIGN_CHECK_EN changes the misaligned-access expectations.
module tb_load_store_unit;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        mem_enable;
   logic        mem_write;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_wmask;
   logic [31:0] mem_rdata;

   load_store_unit dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_enable(mem_enable), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem [0:127];
   logic [7:0] ref_mem [0:127];

   // model of the outstanding request
   bit          outstanding = 0;
   int          age = 0;
   bit          e_err;
   bit          e_w;
   int          e_addr;
   int          e_n;
   logic [31:0] e_wdata;
   logic [31:0] e_mask;
   logic [31:0] e_rdata;

   initial clock = 0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // memory: combinational read, rising-edge masked write
   always_comb begin
      mem_rdata = 32'hA5A5_A5A5;
      if (mem_enable && !mem_write) begin
         mem_rdata = 32'h0;
         for (int i = 0; i < 4; i++)
            if (int'(mem_addr) + i < 128)
               mem_rdata[8*i +: 8] = mem[int'(mem_addr) + i];
      end
   end

   always @(posedge clock) begin
      if (mem_enable && mem_write)
         for (int i = 0; i < 4; i++)
            if (int'(mem_addr) + i < 128)
               mem[int'(mem_addr) + i] =
                  (mem[int'(mem_addr) + i] & ~mem_wmask[8*i +: 8]) |
                  (mem_wdata[8*i +: 8] & mem_wmask[8*i +: 8]);
   end

   // spec-level expectation for one request
   task automatic model(input bit w, input logic [1:0] sz, input bit s,
                        input logic [31:0] a, input logic [31:0] d);
      logic [63:0] v;
      longint la;
      int n;
      n  = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
      la = longint'(a);
      e_err = (sz == 3) || (la >= 128) || (la + n > 128);
`ifdef LSU_ALIGN_CHECK_EN
      if ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) e_err = 1;
`endif
      e_w     = w;
      e_n     = n;
      e_addr  = e_err ? 0 : int'(a);
      e_wdata = d;
      e_mask  = e_err ? 32'h0 : (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*n)) - 1);
      e_rdata = 32'h0;
      if (!e_err && !w) begin
         v = 64'h0;
         for (int i = 0; i < n; i++) v = v | (64'(ref_mem[e_addr + i]) << (8*i));
         if (s && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 1);
         e_rdata = v[31:0];
      end
   endtask

   // model timeline: accept, commit store at end of access, retire on handshake
   always @(posedge clock) begin
      if (reset) begin
         outstanding = 0;
         age = 0;
      end else if (!outstanding) begin
         if (req_valid) begin
            model(req_write, req_size, req_signed, req_addr, req_wdata);
            outstanding = 1;
            age = 1;
         end
      end else if (age == 1) begin
         if (!e_err && e_w)
            for (int i = 0; i < e_n; i++) ref_mem[e_addr + i] = e_wdata[8*i +: 8];
         age = 2;
      end else if (resp_ready) begin
         outstanding = 0;
         age = 0;
      end
   end

   // per-cycle output check
   always @(negedge clock) begin
      if (!reset) begin
         if (!outstanding) begin
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            chk("idle_mem_enable", 32'(mem_enable), 32'd0);
         end else if (age == 1) begin
            chk("acc_req_ready", 32'(req_ready), 32'd0);
            chk("acc_resp_valid", 32'(resp_valid), 32'd0);
            chk("acc_mem_enable", 32'(mem_enable), 32'(!e_err));
            chk("acc_mem_write", 32'(mem_write), 32'(!e_err && e_w));
            chk("acc_mem_wmask", mem_wmask, e_mask);
            if (!e_err) begin
               chk("acc_mem_addr", 32'(mem_addr), 32'(e_addr));
               chk("acc_mem_wdata", mem_wdata, e_wdata);
            end
         end else begin
            chk("rsp_req_ready", 32'(req_ready), 32'd0);
            chk("rsp_mem_enable", 32'(mem_enable), 32'd0);
            chk("rsp_valid", 32'(resp_valid), 32'd1);
            chk("rsp_error", 32'(resp_error), 32'(e_err));
            chk("rsp_rdata", resp_rdata, e_rdata);
         end
      end
   end

   task automatic scramble();
      req_valid  = 1'($urandom);
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic xfer(input bit w, input logic [1:0] sz, input bit s,
                       input logic [31:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] got, output logic got_err);
      @(negedge clock);
      #1;
      req_valid = 1; req_write = w; req_size = sz;
      req_signed = s; req_addr = a; req_wdata = d;
      @(posedge clock);
      #1 scramble();
      @(posedge clock);
      #1 scramble();
      @(negedge clock);
      got = resp_rdata;
      got_err = resp_error;
      repeat (hold) begin
         @(posedge clock);
         #1 scramble();
      end
      #1;
      req_valid = 0;
      resp_ready = 1;
      @(posedge clock);
      #1 resp_ready = 0;
   endtask

   logic [31:0] got;
   logic        gerr;
   int          diffs;

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'h0;
         ref_mem[i] = 8'h0;
      end
      reset = 1; req_valid = 0; req_write = 0; req_size = 0;
      req_signed = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
      #12;
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_mem_enable", 32'(mem_enable), 32'd0);
      @(negedge clock);
      #1 reset = 0;

      xfer(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, got, gerr);
      xfer(0, 2, 0, 32'h10, 32'h0, 0, got, gerr);
      chk("lw_10", got, 32'hDEADBEEF);
      chk("lw_10_err", 32'(gerr), 32'd0);
      xfer(1, 0, 0, 32'h11, 32'h80, 0, got, gerr);
      xfer(0, 0, 1, 32'h11, 32'h0, 3, got, gerr);
      chk("lb_11", got, 32'hFFFFFF80);
      xfer(0, 0, 0, 32'h11, 32'h0, 1, got, gerr);
      chk("lbu_11", got, 32'h00000080);
      xfer(0, 2, 0, 32'h10, 32'h0, 0, got, gerr);
      chk("lw_10_b", got, 32'hDEAD80EF);

      xfer(0, 2, 0, 32'h7E, 32'h0, 0, got, gerr);
      chk("lw_7e_err", 32'(gerr), 32'd1);
      xfer(0, 1, 0, 32'h7E, 32'h0, 0, got, gerr);
      chk("lh_7e_err", 32'(gerr), 32'd0);
      xfer(0, 2, 0, 32'h100, 32'h0, 0, got, gerr);
      chk("lw_100_err", 32'(gerr), 32'd1);
      xfer(0, 3, 0, 32'h0, 32'h0, 0, got, gerr);
      chk("size3_err", 32'(gerr), 32'd1);

      xfer(0, 1, 0, 32'h13, 32'h0, 0, got, gerr);
`ifdef LSU_ALIGN_CHECK_EN
      chk("lh_13_err", 32'(gerr), 32'd1);
      chk("lh_13_data", got, 32'h0);
`else
      chk("lh_13_err", 32'(gerr), 32'd0);
      chk("lh_13_data", got, 32'h000000DE);
`endif

      // reset in the middle of a store access
      @(negedge clock);
      #1;
      req_valid = 1; req_write = 1; req_size = 2;
      req_signed = 0; req_addr = 32'h20; req_wdata = 32'h12345678;
      @(posedge clock);
      #1 req_valid = 0;
      @(negedge clock);
      #1 reset = 1;
      #1;
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_wmask", mem_wmask, 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1 reset = 0;
      xfer(0, 2, 0, 32'h20, 32'h0, 0, got, gerr);
      chk("lw_20_after_rst", got, 32'h0);

      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 3) != 0 && sz == 2) a = a & ~32'h3;
         xfer(1'($urandom), sz, 1'($urandom), a, $urandom,
              $urandom_range(0, 3), got, gerr);
      end

      diffs = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image", 32'(diffs), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
